// File: rtl/koder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : koder_pkg
// Description : Shared types and constants for the two-channel encoder
//               arbiter: FSM state encoding, channel ids, code offsets.
// Revision    : 1.0 - initial release
// ============================================================================
package koder_pkg;

  // Controller states: idle/accept, encode, hold output
  typedef enum logic [1:0] {
    MIR = 2'd0,
    KOD = 2'd1,
    IZL = 2'd2
  } stanje_t;

  // Channel identifiers as carried on izl_kanal
  localparam logic KANAL_IME    = 1'b0;
  localparam logic KANAL_INDEKS = 1'b1;

  // Offsets of the add-3/add-5 parity code
  localparam int DODAJ_PAR   = 3;
  localparam int DODAJ_NEPAR = 5;

endpackage : koder_pkg
`default_nettype wire

// File: rtl/koder_jezgro.sv
`default_nettype none
// ============================================================================
// Module      : koder_jezgro
// Description : Combinational add-3/add-5 parity encoder. Even words get +3,
//               odd words +5, modulo the channel width; the LSB of the input
//               is placed as a flag just above the channel width. With the
//               narrow select active, everything above the flag is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module koder_jezgro
  import koder_pkg::*;
#(
  parameter int W0 = 40,
  parameter int W1 = 12
) (
  input  logic [W0-1:0] i_podatak,
  input  logic          i_uzak,
  output logic [W0:0]   o_kod
);

  logic [W0-1:0] w_dodaj;
  logic [W0-1:0] w_zbir;
  logic [W0-1:0] w_maska;

  // Select offset by parity, add, and place the flag at the channel width
  always_comb begin
    w_dodaj = i_podatak[0] ? W0'(DODAJ_NEPAR) : W0'(DODAJ_PAR);
    w_zbir  = i_podatak + w_dodaj;
    w_maska = {W0{1'b1}} >> (W0 - W1);
    o_kod   = '0;
    if (i_uzak) begin
      // Narrow channel: keep the low W1 sum bits, flag sits at bit W1
      o_kod[W0-1:0] = w_zbir & w_maska;
      o_kod[W1]     = i_podatak[0];
    end else begin
      o_kod = {i_podatak[0], w_zbir};
    end
  end

endmodule : koder_jezgro
`default_nettype wire

// File: rtl/koder_arbitar.sv
`default_nettype none
// ============================================================================
// Module      : koder_arbitar
// Description : Round-robin arbiter sharing one parity encoder between the
//               40-bit ime channel and the 12-bit indeks channel. A granted
//               word is latched, encoded one cycle later and held on a
//               valid/ready output until taken. Per-channel saturating
//               counters track delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module koder_arbitar
  import koder_pkg::*;
#(
  parameter int W0    = 40,
  parameter int W1    = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ime_valid,
  output logic             ime_ready,
  input  logic [W0-1:0]    ime,
  input  logic             indeks_valid,
  output logic             indeks_ready,
  input  logic [W1-1:0]    indeks,
  output logic             izl_valid,
  input  logic             izl_ready,
  output logic [W0:0]      izl_kod,
  output logic             izl_kanal,
  output logic [CNT_W-1:0] cnt_ime,
  output logic [CNT_W-1:0] cnt_indeks
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  stanje_t          r_stanje;
  stanje_t          w_stanje_sl;
  logic             r_prio;
  logic [W0-1:0]    r_podatak;
  logic             r_kanal;
  logic             r_izl_valid;
  logic [W0:0]      r_izl_kod;
  logic             r_izl_kanal;
  logic [CNT_W-1:0] r_cnt_ime;
  logic [CNT_W-1:0] r_cnt_indeks;

  logic             w_grant_ime;
  logic             w_grant_indeks;
  logic             w_prihvat;
  logic             w_izl_hs;
  logic [W0:0]      w_kod;

  // Grant only while idle; a lone requester wins, a tie goes to prio.
  // Gated by reset so no handshake is offered while reset is asserted.
  always_comb begin
    w_grant_ime    = 1'b0;
    w_grant_indeks = 1'b0;
    if (rst_n && (r_stanje == MIR)) begin
      if (ime_valid && indeks_valid) begin
        w_grant_ime    = (r_prio == KANAL_IME);
        w_grant_indeks = (r_prio == KANAL_INDEKS);
      end else begin
        w_grant_ime    = ime_valid;
        w_grant_indeks = indeks_valid;
      end
    end
  end

  assign ime_ready    = w_grant_ime;
  assign indeks_ready = w_grant_indeks;
  assign w_prihvat    = w_grant_ime | w_grant_indeks;
  assign w_izl_hs     = r_izl_valid & izl_ready;

  // Next-state logic
  always_comb begin
    w_stanje_sl = r_stanje;
    unique case (r_stanje)
      MIR:     if (w_prihvat) w_stanje_sl = KOD;
      KOD:     w_stanje_sl = IZL;
      IZL:     if (w_izl_hs) w_stanje_sl = MIR;
      default: w_stanje_sl = MIR;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_stanje <= MIR;
    else        r_stanje <= w_stanje_sl;
  end

  // Latch the granted word, zero-extended, together with its channel id
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_podatak <= '0;
      r_kanal   <= KANAL_IME;
    end else if (w_prihvat) begin
      r_podatak <= w_grant_indeks ? W0'(indeks) : ime;
      r_kanal   <= w_grant_indeks;
    end
  end

  koder_jezgro #(
    .W0 (W0),
    .W1 (W1)
  ) u_jezgro (
    .i_podatak (r_podatak),
    .i_uzak    (r_kanal),
    .o_kod     (w_kod)
  );

  // Output buffer: loaded on leaving KOD, held until the downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_izl_valid <= 1'b0;
      r_izl_kod   <= '0;
      r_izl_kanal <= KANAL_IME;
    end else if (r_stanje == KOD) begin
      r_izl_valid <= 1'b1;
      r_izl_kod   <= w_kod;
      r_izl_kanal <= r_kanal;
    end else if (w_izl_hs) begin
      r_izl_valid <= 1'b0;
    end
  end

  // Served counters and round-robin pointer advance on output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_ime    <= '0;
      r_cnt_indeks <= '0;
      r_prio       <= KANAL_IME;
    end else if (w_izl_hs) begin
      r_prio <= ~r_izl_kanal;
      if (r_izl_kanal == KANAL_IME) begin
        if (r_cnt_ime != c_cnt_max) r_cnt_ime <= r_cnt_ime + 1'b1;
      end else begin
        if (r_cnt_indeks != c_cnt_max) r_cnt_indeks <= r_cnt_indeks + 1'b1;
      end
    end
  end

  assign izl_valid  = r_izl_valid;
  assign izl_kod    = r_izl_kod;
  assign izl_kanal  = r_izl_kanal;
  assign cnt_ime    = r_cnt_ime;
  assign cnt_indeks = r_cnt_indeks;

endmodule : koder_arbitar
`default_nettype wire

// File: tb/tb_koder_arbitar.sv
`default_nettype none
// ============================================================================
// Module      : tb_koder_arbitar
// Description : Self-checking bench for koder_arbitar: directed encodings,
//               alternation, backpressure, mid-operation reset, counter
//               saturation and a randomized run against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_koder_arbitar;

  localparam int W0    = 40;
  localparam int W1    = 12;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk;
  logic             rst_n;
  logic             ime_valid;
  logic             ime_ready;
  logic [W0-1:0]    ime;
  logic             indeks_valid;
  logic             indeks_ready;
  logic [W1-1:0]    indeks;
  logic             izl_valid;
  logic             izl_ready;
  logic [W0:0]      izl_kod;
  logic             izl_kanal;
  logic [CNT_W-1:0] cnt_ime;
  logic [CNT_W-1:0] cnt_indeks;

  int n_checks = 0;
  int n_fail   = 0;

  koder_arbitar #(.W0(W0), .W1(W1), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ime_valid    (ime_valid),
    .ime_ready    (ime_ready),
    .ime          (ime),
    .indeks_valid (indeks_valid),
    .indeks_ready (indeks_ready),
    .indeks       (indeks),
    .izl_valid    (izl_valid),
    .izl_ready    (izl_ready),
    .izl_kod      (izl_kod),
    .izl_kanal    (izl_kanal),
    .cnt_ime      (cnt_ime),
    .cnt_indeks   (cnt_indeks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding from the code definition, plain integer arithmetic
  function automatic logic [W0:0] exp_code(input bit ch, input logic [W0-1:0] x);
    longint unsigned xv, m, s;
    int w;
    w  = ch ? W1 : W0;
    m  = 64'd1 << w;
    xv = 64'(x);
    xv = xv % m;
    s  = (xv + (((xv % 2) == 1) ? 64'd5 : 64'd3)) % m;
    return (W0+1)'(s + (xv % 2) * m);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // Offer one word on a channel with izl_ready high; report what came out
  task automatic xfer(input bit ch, input logic [W0-1:0] d, output logic [W0:0] kod,
                      output bit kanal, output int lat, output bit ok);
    ok = 1'b0; lat = -1; kod = '0; kanal = 1'b0;
    izl_ready = 1'b1;
    if (ch) begin indeks_valid = 1'b1; indeks = d[W1-1:0]; end
    else    begin ime_valid = 1'b1; ime = d; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ch ? indeks_ready : ime_ready) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    ime_valid = 1'b0; indeks_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (izl_valid) begin ok = 1'b1; lat = i; kod = izl_kod; kanal = izl_kanal; break; end
        cyc();
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ime_valid = 1'b1; indeks_valid = 1'b1; izl_ready = 1'b1;
    ime = '1; indeks = '1;
    #1;
    n_checks++;
    if ({ime_ready, indeks_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_readies: got %b expected 00", {ime_ready, indeks_ready});
    end
    cyc();
    n_checks++;
    if ({izl_valid, izl_kod, izl_kanal, cnt_ime, cnt_indeks} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b kod=%h k=%b c0=%0d c1=%0d expected all 0",
               izl_valid, izl_kod, izl_kanal, cnt_ime, cnt_indeks);
    end
    ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_ime_basic();
    logic [W0:0] kod; bit kanal, ok; int lat;
    do_reset();
    xfer(1'b0, 40'h0000000002, kod, kanal, lat, ok);
    n_checks++;
    if (!ok || kod !== 41'h00000000005 || kanal !== 1'b0 || lat !== 1) begin
      n_fail++; $display("FAIL ime_even: got ok=%b kod=%h k=%b lat=%0d expected kod=00000000005 k=0 lat=1", ok, kod, kanal, lat);
    end
    xfer(1'b0, 40'h0000000003, kod, kanal, lat, ok);
    n_checks++;
    if (!ok || kod !== 41'h10000000008 || kanal !== 1'b0) begin
      n_fail++; $display("FAIL ime_odd: got ok=%b kod=%h k=%b expected 10000000008 k=0", ok, kod, kanal);
    end
    n_checks++;
    if (cnt_ime !== 4'd2 || cnt_indeks !== 4'd0 || izl_valid !== 1'b0) begin
      n_fail++; $display("FAIL ime_counts: got c0=%0d c1=%0d v=%b expected 2 0 0", cnt_ime, cnt_indeks, izl_valid);
    end
  endtask

  task automatic test_indeks_basic();
    logic [W0:0] kod; bit kanal, ok; int lat;
    do_reset();
    xfer(1'b1, 40'hFFE, kod, kanal, lat, ok);
    n_checks++;
    if (!ok || kod !== 41'h0001 || kanal !== 1'b1 || lat !== 1) begin
      n_fail++; $display("FAIL indeks_wrap: got ok=%b kod=%h k=%b lat=%0d expected 0001 k=1 lat=1", ok, kod, kanal, lat);
    end
    xfer(1'b1, 40'hFFF, kod, kanal, lat, ok);
    n_checks++;
    if (!ok || kod !== 41'h1004 || kanal !== 1'b1) begin
      n_fail++; $display("FAIL indeks_odd: got ok=%b kod=%h k=%b expected 1004 k=1", ok, kod, kanal);
    end
    n_checks++;
    if (cnt_ime !== 4'd0 || cnt_indeks !== 4'd2) begin
      n_fail++; $display("FAIL indeks_counts: got c0=%0d c1=%0d expected 0 2", cnt_ime, cnt_indeks);
    end
  endtask

  task automatic test_alternation();
    bit m_prio; int m_cnt0, m_cnt1, words, grants;
    logic [W0:0] e_kod; bit e_kanal;
    do_reset();
    m_prio = 1'b0; m_cnt0 = 0; m_cnt1 = 0; words = 0; grants = 0;
    e_kod = '0; e_kanal = 1'b0;
    izl_ready = 1'b1; ime_valid = 1'b1; indeks_valid = 1'b1;
    for (int c = 0; c < 60 && words < 6; c++) begin
      ime = {8'($urandom), $urandom};
      indeks = 12'($urandom);
      #1;
      if (ime_ready || indeks_ready) begin
        n_checks++;
        if (ime_ready === indeks_ready || indeks_ready !== m_prio) begin
          n_fail++; $display("FAIL alt_grant: got ready=%b%b expected grant to ch %0d", ime_ready, indeks_ready, m_prio);
        end
        e_kanal = m_prio;
        e_kod   = exp_code(m_prio, m_prio ? 40'(indeks) : ime);
        grants++;
      end
      if (izl_valid) begin
        n_checks++;
        if (izl_kod !== e_kod || izl_kanal !== e_kanal) begin
          n_fail++; $display("FAIL alt_word: got kod=%h k=%b expected kod=%h k=%b", izl_kod, izl_kanal, e_kod, e_kanal);
        end
        if (e_kanal) m_cnt1++; else m_cnt0++;
        m_prio = ~e_kanal;
        words++;
      end
      cyc();
    end
    ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
    n_checks++;
    if (words !== 6 || cnt_ime !== CNT_W'(m_cnt0) || cnt_indeks !== CNT_W'(m_cnt1) || m_cnt0 !== 3) begin
      n_fail++; $display("FAIL alt_counts: got words=%0d c0=%0d c1=%0d expected 6 3 3", words, cnt_ime, cnt_indeks);
    end
  endtask

  task automatic test_backpressure();
    logic [W0:0] e_kod;
    do_reset();
    ime = {8'($urandom), $urandom};
    e_kod = exp_code(1'b0, ime);
    ime_valid = 1'b1; indeks_valid = 1'b0; izl_ready = 1'b0;
    cyc();
    indeks_valid = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (izl_valid !== 1'b1 || izl_kod !== e_kod || izl_kanal !== 1'b0 ||
          ime_ready !== 1'b0 || indeks_ready !== 1'b0 || cnt_ime !== 4'd0) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b kod=%h k=%b rdy=%b%b c0=%0d expected v=1 kod=%h k=0 rdy=00 c0=0",
                 izl_valid, izl_kod, izl_kanal, ime_ready, indeks_ready, cnt_ime, e_kod);
      end
      cyc();
    end
    izl_ready = 1'b1;
    cyc();
    #1;
    n_checks++;
    if (izl_valid !== 1'b0 || cnt_ime !== 4'd1 || indeks_ready !== 1'b1 || ime_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b c0=%0d rdy=%b%b expected v=0 c0=1 rdy=01",
               izl_valid, cnt_ime, ime_ready, indeks_ready);
    end
    ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [W0:0] kod; bit kanal, ok; int lat;
    do_reset();
    xfer(1'b0, 40'h0000000003, kod, kanal, lat, ok);
    izl_ready = 1'b1; ime = 40'h0000000007; ime_valid = 1'b1;
    cyc();
    ime_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({izl_valid, izl_kod, izl_kanal, cnt_ime, cnt_indeks, ime_ready, indeks_ready} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b kod=%h k=%b c0=%0d c1=%0d rdy=%b%b expected all 0",
               izl_valid, izl_kod, izl_kanal, cnt_ime, cnt_indeks, ime_ready, indeks_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (izl_valid !== 1'b0 || cnt_ime !== 4'd0) begin
        n_fail++; $display("FAIL midreset_dropped: got v=%b c0=%0d expected v=0 c0=0", izl_valid, cnt_ime);
      end
    end
    izl_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [W0:0] kod; bit kanal, ok; int lat, m;
    do_reset();
    m = 0;
    for (int i = 1; i <= 20; i++) begin
      xfer(1'b0, {8'($urandom), $urandom}, kod, kanal, lat, ok);
      m = sat_inc(m);
      n_checks++;
      if (!ok || cnt_ime !== CNT_W'(m)) begin
        n_fail++; $display("FAIL sat_step%0d: got ok=%b c0=%0d expected %0d", i, ok, cnt_ime, m);
      end
    end
    n_checks++;
    if (cnt_ime !== 4'd15 || cnt_indeks !== 4'd0) begin
      n_fail++; $display("FAIL sat_final: got c0=%0d c1=%0d expected 15 0", cnt_ime, cnt_indeks);
    end
  endtask

  // Random valids/data/backpressure against a timeline model of the block
  task automatic test_random();
    bit m_prio, busy, e_rdy0, e_rdy1, e_valid, e_kanal;
    int age, m_cnt0, m_cnt1, errs;
    logic [W0:0] e_kod;
    do_reset();
    m_prio = 1'b0; busy = 1'b0; age = 0; m_cnt0 = 0; m_cnt1 = 0;
    e_kod = '0; e_kanal = 1'b0; errs = 0;
    for (int c = 0; c < 600; c++) begin
      ime_valid    = ($urandom_range(0, 2) != 0);
      indeks_valid = ($urandom_range(0, 2) != 0);
      izl_ready    = ($urandom_range(0, 2) != 0);
      ime          = {8'($urandom), $urandom};
      indeks       = 12'($urandom);
      #1;
      if (busy) age++;
      e_valid = busy && (age >= 2);
      if (!busy && ime_valid && indeks_valid) begin
        e_rdy0 = (m_prio == 1'b0); e_rdy1 = (m_prio == 1'b1);
      end else begin
        e_rdy0 = !busy && ime_valid; e_rdy1 = !busy && indeks_valid;
      end
      n_checks++;
      if (cnt_ime !== CNT_W'(m_cnt0) || cnt_indeks !== CNT_W'(m_cnt1) || izl_valid !== e_valid ||
          ime_ready !== e_rdy0 || indeks_ready !== e_rdy1 ||
          (e_valid && (izl_kod !== e_kod || izl_kanal !== e_kanal))) begin
        n_fail++; errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d: got v=%b rdy=%b%b kod=%h k=%b c=%0d/%0d expected v=%b rdy=%b%b kod=%h k=%b c=%0d/%0d",
                   c, izl_valid, ime_ready, indeks_ready, izl_kod, izl_kanal, cnt_ime, cnt_indeks,
                   e_valid, e_rdy0, e_rdy1, e_kod, e_kanal, m_cnt0, m_cnt1);
      end
      if (e_valid && izl_ready) begin
        if (e_kanal) m_cnt1 = sat_inc(m_cnt1); else m_cnt0 = sat_inc(m_cnt0);
        m_prio = ~e_kanal;
        busy = 1'b0;
      end else if (e_rdy0 || e_rdy1) begin
        busy = 1'b1; age = 0;
        e_kanal = e_rdy1;
        e_kod = exp_code(e_rdy1, e_rdy1 ? 40'(indeks) : ime);
      end
      cyc();
    end
    ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ime_valid = 1'b0; indeks_valid = 1'b0; izl_ready = 1'b0;
    ime = '0; indeks = '0;
    cyc();
    test_reset();
    test_ime_basic();
    test_indeks_basic();
    test_alternation();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_koder_arbitar
`default_nettype wire

// File: doc/koder_arbitar.md
# koder_arbitar

Sequential controller that shares one encoder datapath between two requesters: the 40-bit `ime` channel and the 12-bit `indeks` channel. Each requester offers words over a valid/ready handshake. The block arbitrates round-robin, encodes the granted word with the team's add-3/add-5 parity code, and presents the result with its channel tag on a single buffered valid/ready output. It sits in front of the downstream decoder and keeps per-channel served-word counters.

## Interface
Parameters:
- `W0`, 40, width of `ime` channel data
- `W1`, 12, width of `indeks` channel data; requires W1 < W0
- `CNT_W`, 16, width of the per-channel served counters

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `ime_valid`  in  1  channel 0 word offered
- `ime_ready`  out  1  channel 0 word accepted this cycle
- `ime`  in  W0  channel 0 data
- `indeks_valid`  in  1  channel 1 word offered
- `indeks_ready`  out  1  channel 1 word accepted this cycle
- `indeks`  in  W1  channel 1 data
- `izl_valid`  out  1  encoded word available
- `izl_ready`  in  1  downstream accepts
- `izl_kod`  out  W0+1  encoded word; channel 1 uses bits [W1:0], upper bits 0
- `izl_kanal`  out  1  0 = ime, 1 = indeks
- `cnt_ime`  out  CNT_W  words delivered from channel 0, saturating
- `cnt_indeks`  out  CNT_W  words delivered from channel 1, saturating

## Operation
- FSM states:
  - MIR (idle): accepts a request.
  - KOD: encodes the latched word.
  - IZL: holds the output until the downstream handshake.
- Transitions:
  - MIR → KOD on any accepted request.
  - KOD → IZL unconditionally.
  - IZL → MIR on `izl_valid && izl_ready`.
- Grant logic:
  - In MIR only: a single valid requester is granted.
  - If both are valid, channel `prio` is granted.
  - `ime_ready`/`indeks_ready` = (state==MIR) && granted. This is combinational from the valids. Both readies are 0 in KOD and IZL.
- On acceptance: latch data zero-extended to W0 and latch the channel id.
- Encoding, with x as the latched word and W the channel width:
  - x[0]==0 → kod = {0, (x+3) mod 2^W}.
  - x[0]==1 → kod = {1, (x+5) mod 2^W}.
  - The flag sits at bit W. For channel 1, bits above W1 are forced to 0.
- On output handshake:
  - Increment the served channel's counter, saturating at 2^CNT_W−1.
  - Set `prio` to the other channel.
- Reset, which also applies mid-operation: state MIR, `prio`=0, `izl_valid`=0, `izl_kod`=0, `izl_kanal`=0, both counters 0, both readies 0. Any latched word is discarded and is not counted.

## Timing
- Request accepted at edge N → `izl_valid`=1 from the cycle after edge N+1. Latency is 2 cycles.
- Best-case throughput: one word per 3 cycles (MIR, KOD, IZL with `izl_ready` held high).
- While `izl_valid`=1 and `izl_ready`=0: `izl_kod` and `izl_kanal` hold stable, and no new request is accepted.
- `izl_valid` drops in the cycle after the handshake edge. The counter update is visible in the same cycle.
- A valid held during KOD/IZL waits. There is no requirement that a requester keep its data stable until accepted, because data is sampled only on the accept edge.

## Structure
- Package `koder_pkg` holds:
  - the state enum (MIR, KOD, IZL);
  - channel id constants KANAL_IME=0, KANAL_INDEKS=1;
  - code constants DODAJ_PAR=3, DODAJ_NEPAR=5.
- Sub-module `koder_jezgro` is the combinational encoder, parameterised W0. Its inputs are the W0-bit data and a width select; its output is the W0+1-bit code with the channel-1 mask applied. The FSM, arbiter and counters live in `koder_arbitar`.

## Test plan
- `ime`=40'h0000000002 offered alone → `izl_kod`=41'h00000000005 and `izl_kanal`=0, two cycles after accept. Then `ime`=40'h0000000003 → 41'h10000000008.
- `indeks`=12'hFFE → `izl_kod`=41'h0001, wrapping mod 2^12. Then `indeks`=12'hFFF → 41'h1004, `izl_kanal`=1.
- Both valid right after reset, held → `ime` is served first, then `indeks`, then `ime`. Grants strictly alternate and `cnt_ime`/`cnt_indeks` advance alternately.
- `izl_ready` held 0 for 5 cycles while in IZL → output stable, both readies 0, counters unchanged. On release there is one handshake and return to MIR.
- `rst_n`=0 for one cycle while in KOD → next cycle all outputs 0, state MIR. The word is not delivered and not counted.
- With CNT_W=4, deliver 20 `ime` words → `cnt_ime` saturates at 15, `cnt_indeks` stays 0.
